// File: rtl/sobel_edge3x3.sv
// sobel_edge3x3: streaming 3x3 Sobel edge detector.
// Two line buffers build a 3x3 window; the gradient magnitude of the window
// centre is produced two cycles after each accepted pixel.
// Define SOBEL_MAG_EN to output (|Gx|+|Gy|) instead of the single gradient
// selected per frame by iSEL.
module sobel_edge3x3 #(
  parameter int WIDTH = 1280,
  parameter int SHIFT = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iDATA,
  input  logic [10:0] iX_Cont,
  input  logic [10:0] iY_Cont,
  input  logic        iDVAL,
  input  logic        iSEL,
  output logic [11:0] oDATA,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic        oDVAL
);

  localparam int          AW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [11:0] WIDTH_L = 12'(WIDTH);

  logic          accept;
  logic          frame_start;
  logic [AW-1:0] addr;
  logic [11:0]   lb0 [WIDTH];
  logic [11:0]   lb1 [WIDTH];
  logic [11:0]   lb0_rd, lb1_rd;

  // win[r][c]: r=0 oldest row, c=2 newest column
  logic [2:0][2:0][11:0] win_q, win_d;
  logic                  armed_q, armed_d;
  logic                  va_q, va_d;
  logic [10:0]           xa_q, ya_q;

  logic [13:0]        sum_r, sum_l, sum_b, sum_t;
  logic signed [14:0] gx, gy;
  logic [13:0]        ax, ay;
  logic [15:0]        mag, shifted;
  logic [11:0]        sat;

  logic [11:0] data_q;
  logic [10:0] xo_q, yo_q;
  logic        dval_q;

  assign accept      = iDVAL && ({1'b0, iX_Cont} < WIDTH_L);
  assign frame_start = accept && (iX_Cont == '0) && (iY_Cont == '0);
  assign addr        = iX_Cont[AW-1:0];
  assign lb0_rd      = lb0[addr];
  assign lb1_rd      = lb1[addr];

  // Line buffers shift down one row per accepted pixel; contents are not reset
  always_ff @(posedge iCLK) begin
    if (accept) begin
      lb1[addr] <= lb0_rd;
      lb0[addr] <= iDATA;
    end
  end

  // Next window, arming and stage-A qualification
  always_comb begin
    win_d   = win_q;
    armed_d = frame_start ? 1'b1 : armed_q;
    if (accept) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = iDATA;
    end
    va_d = accept && armed_d && (iX_Cont >= 11'd2) && (iY_Cont >= 11'd2);
  end

`ifndef SOBEL_MAG_EN
  logic fsel_q, fsel_d, sel_a_q;

  // Gradient select is latched at frame start and held for the whole frame
  always_comb begin
    fsel_d = frame_start ? iSEL : fsel_q;
  end

  // Frame select and its stage-A copy
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      fsel_q  <= 1'b0;
      sel_a_q <= 1'b0;
    end else begin
      fsel_q <= fsel_d;
      if (accept) sel_a_q <= fsel_d;
    end
  end
`endif

  // Stage A: window shift, arming, centre coordinate capture
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      win_q   <= '0;
      armed_q <= 1'b0;
      va_q    <= 1'b0;
      xa_q    <= '0;
      ya_q    <= '0;
    end else begin
      win_q   <= win_d;
      armed_q <= armed_d;
      va_q    <= va_d;
      if (accept) begin
        xa_q <= iX_Cont;
        ya_q <= iY_Cont;
      end
    end
  end

  // Gradient arithmetic on the registered window
  always_comb begin
    sum_r = {2'b00, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b00, win_q[2][2]};
    sum_l = {2'b00, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b00, win_q[2][0]};
    sum_b = {2'b00, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b00, win_q[2][2]};
    sum_t = {2'b00, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b00, win_q[0][2]};
    gx    = $signed({1'b0, sum_r}) - $signed({1'b0, sum_l});
    gy    = $signed({1'b0, sum_b}) - $signed({1'b0, sum_t});
    ax    = gx[14] ? 14'(-gx) : gx[13:0];
    ay    = gy[14] ? 14'(-gy) : gy[13:0];
`ifdef SOBEL_MAG_EN
    mag   = {2'b00, ax} + {2'b00, ay};
`else
    mag   = {2'b00, (sel_a_q ? ay : ax)};
`endif
    shifted = mag >> SHIFT;
    sat     = (shifted > 16'd4095) ? 12'hFFF : shifted[11:0];
  end

  // Stage B: outputs update only on qualified pixels, otherwise hold
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      dval_q <= 1'b0;
      data_q <= '0;
      xo_q   <= '0;
      yo_q   <= '0;
    end else begin
      dval_q <= va_q;
      if (va_q) begin
        data_q <= sat;
        xo_q   <= xa_q - 11'd1;
        yo_q   <= ya_q - 11'd1;
      end
    end
  end

  assign oDATA   = data_q;
  assign oX_Cont = xo_q;
  assign oY_Cont = yo_q;
  assign oDVAL   = dval_q;

endmodule

// File: tb/tb_sobel_edge3x3.sv
// Testbench for sobel_edge3x3: two instances (SHIFT=2 and SHIFT=0) share the
// input stream; a picture-level Sobel model predicts every output event.
module tb_sobel_edge3x3;

  localparam int W = 16;
  localparam int H = 8;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [11:0] iDATA = '0;
  logic [10:0] iX = '0, iY = '0;
  logic        iDVAL = 1'b0, iSEL = 1'b0;
  logic [11:0] d2, d0;
  logic [10:0] x2, y2, x0, y0;
  logic        v2, v0;

  sobel_edge3x3 #(.WIDTH(W), .SHIFT(2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iX_Cont(iX), .iY_Cont(iY),
    .iDVAL(iDVAL), .iSEL(iSEL), .oDATA(d2), .oX_Cont(x2), .oY_Cont(y2), .oDVAL(v2));

  sobel_edge3x3 #(.WIDTH(W), .SHIFT(0)) dut0 (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iX_Cont(iX), .iY_Cont(iY),
    .iDVAL(iDVAL), .iSEL(iSEL), .oDATA(d0), .oX_Cont(x0), .oY_Cont(y0), .oDVAL(v0));

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [11:0] d2;
    logic [11:0] d0;
    logic [10:0] x2;
    logic [10:0] y2;
    logic [10:0] x0;
    logic [10:0] y0;
    logic        v2;
    logic        v0;
    logic [31:0] due;
  } ev_t;

  ev_t expq[$];
  ev_t capq[$];
  int  edges  = 0;
  int  checks = 0;
  int  passes = 0;
  int  img [H][W];
  bit  m_armed = 1'b0;
  bit  m_sel   = 1'b0;

  // Output recorder: every cycle with a valid output from either instance
  initial begin
    forever begin
      @(posedge iCLK);
      edges++;
      #1;
      if (v2 || v0) begin
        ev_t e;
        e = '{d2: d2, d0: d0, x2: x2, y2: y2, x0: x0, y0: y0, v2: v2, v0: v0,
              due: 32'(edges)};
        capq.push_back(e);
      end
    end
  end

  function automatic logic [11:0] sat_shift(int m, int sh);
    int s;
    s = m >> sh;
    return (s > 4095) ? 12'hFFF : 12'(s);
  endfunction

  // Picture-level model: Sobel on the stored frame image
  task automatic model_accept(int x, int y, int d, bit sel);
    int gx, gy, ax, ay, m;
    ev_t e;
    if (x == 0 && y == 0) begin
      m_armed = 1'b1;
      m_sel   = sel;
    end
    img[y][x] = d;
    if (m_armed && x >= 2 && y >= 2) begin
      gx = (img[y-2][x] + 2*img[y-1][x] + img[y][x])
         - (img[y-2][x-2] + 2*img[y-1][x-2] + img[y][x-2]);
      gy = (img[y][x-2] + 2*img[y][x-1] + img[y][x])
         - (img[y-2][x-2] + 2*img[y-2][x-1] + img[y-2][x]);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
`ifdef SOBEL_MAG_EN
      m = ax + ay;
`else
      m = m_sel ? ay : ax;
`endif
      e = '{d2: sat_shift(m, 2), d0: sat_shift(m, 0), x2: 11'(x-1), y2: 11'(y-1),
            x0: 11'(x-1), y0: 11'(y-1), v2: 1'b1, v0: 1'b1, due: 32'(edges+2)};
      expq.push_back(e);
    end
  endtask

  task automatic drive(int x, int y, int d, bit sel, bit v);
    @(negedge iCLK);
    iX = 11'(x); iY = 11'(y); iDATA = 12'(d); iSEL = sel; iDVAL = v;
    if (v && x < W) model_accept(x, y, d, sel);
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, 0, 1'b0, 1'b0);
  endtask

  function automatic int pix(int kind, int x, int y);
    case (kind)
      0:       return 1000;
      1:       return (x < 8) ? 0 : 1000;
      2:       return (y < 4) ? 0 : 4095;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  // gap: 0 none, 1 idle before every pixel, 2 random idles and ignored x>=W pixels
  task automatic send_rows(int kind, bit sel_a, bit sel_b, int sel_row, int gap,
                           int y_from, int y_to, int x_from);
    bit s;
    for (int y = y_from; y <= y_to; y++) begin
      for (int x = (y == y_from) ? x_from : 0; x < W; x++) begin
        s = (y >= sel_row) ? sel_b : sel_a;
        if (gap == 1) drive(x, y, 4095, s, 1'b0);
        if (gap == 2) begin
          if ($urandom_range(0, 3) == 0) drive(x, y, 0, s, 1'b0);
          if ($urandom_range(0, 7) == 0)
            drive(W + int'($urandom_range(0, 15)), y, int'($urandom_range(0, 4095)), ~s, 1'b1);
        end
        drive(x, y, pix(kind, x, y), s, 1'b1);
      end
    end
    idle(4);
  endtask

  task automatic test_reset;
    iRST = 1'b0;
    repeat (3) @(negedge iCLK);
    checks++;
    if ({d2, x2, y2, v2, d0, x0, y0, v0} !== '0)
      $display("FAIL reset_outputs got d=%0d x=%0d y=%0d v=%0d want all 0", d2, x2, y2, v2);
    else passes++;
    iRST = 1'b1;
    idle(2);
    checks++;
    if (v2 !== 1'b0 || capq.size() != 0)
      $display("FAIL reset_idle_dval got v=%0d events=%0d want 0/0", v2, capq.size());
    else passes++;
  endtask

  task automatic test_flat;
    expq.delete(); capq.delete();
    send_rows(0, 1'b0, 1'b0, H, 0, 0, H-1, 0);
    checks++;
    if (capq.size() != 84) $display("FAIL flat_count got %0d want 84", capq.size());
    else passes++;
    checks++;
    if (capq.size() > 0 && ({capq[0].x2, capq[0].y2, capq[$].x2, capq[$].y2} !== {11'd1, 11'd1, 11'd14, 11'd6}))
      $display("FAIL flat_range got first (%0d,%0d) last (%0d,%0d) want (1,1) (14,6)",
               capq[0].x2, capq[0].y2, capq[$].x2, capq[$].y2);
    else passes++;
    for (int i = 0; i < expq.size(); i++) begin
      ev_t g;
      g = (i < capq.size()) ? capq[i] : '0;
      checks++;
      if (g !== expq[i]) $display("FAIL flat[%0d] got %h want %h", i, g, expq[i]);
      else passes++;
    end
  endtask

  task automatic test_vertical_edge;
    int n1000;
    for (int s = 0; s < 2; s++) begin
      expq.delete(); capq.delete();
      send_rows(1, s[0], s[0], H, 0, 0, H-1, 0);
      n1000 = 0;
      foreach (capq[i]) if (capq[i].d2 == 12'd1000 && (capq[i].x2 == 11'd7 || capq[i].x2 == 11'd8)) n1000++;
      checks++;
`ifdef SOBEL_MAG_EN
      if (n1000 != 12) $display("FAIL vedge_hits sel=%0d got %0d want 12", s, n1000);
`else
      if (n1000 != ((s == 0) ? 12 : 0)) $display("FAIL vedge_hits sel=%0d got %0d want %0d", s, n1000, (s == 0) ? 12 : 0);
`endif
      else passes++;
      checks++;
      if (capq.size() != expq.size()) $display("FAIL vedge_count got %0d want %0d", capq.size(), expq.size());
      else passes++;
      for (int i = 0; i < expq.size(); i++) begin
        ev_t g;
        g = (i < capq.size()) ? capq[i] : '0;
        checks++;
        if (g !== expq[i]) $display("FAIL vedge[%0d] got %h want %h", i, g, expq[i]);
        else passes++;
      end
    end
  endtask

  task automatic test_horizontal_edge;
    int nsat;
    expq.delete(); capq.delete();
    send_rows(2, 1'b1, 1'b1, H, 0, 0, H-1, 0);
    nsat = 0;
    foreach (capq[i]) if (capq[i].d0 == 12'hFFF && (capq[i].y0 == 11'd3 || capq[i].y0 == 11'd4)) nsat++;
    checks++;
    if (nsat != 28) $display("FAIL hedge_saturated got %0d want 28", nsat);
    else passes++;
    for (int i = 0; i < expq.size(); i++) begin
      ev_t g;
      g = (i < capq.size()) ? capq[i] : '0;
      checks++;
      if (g !== expq[i]) $display("FAIL hedge[%0d] got %h want %h", i, g, expq[i]);
      else passes++;
    end
  endtask

  task automatic test_dval_gaps;
    expq.delete(); capq.delete();
    send_rows(1, 1'b0, 1'b0, H, 1, 0, H-1, 0);
    checks++;
    if (capq.size() != expq.size()) $display("FAIL gaps_count got %0d want %0d", capq.size(), expq.size());
    else passes++;
    for (int i = 0; i < expq.size(); i++) begin
      ev_t g;
      g = (i < capq.size()) ? capq[i] : '0;
      checks++;
      if (g !== expq[i]) $display("FAIL gaps[%0d] got %h want %h", i, g, expq[i]);
      else passes++;
    end
  endtask

  task automatic test_sel_toggle;
    int nz;
    for (int f = 0; f < 2; f++) begin
      expq.delete(); capq.delete();
      if (f == 0) send_rows(1, 1'b0, 1'b1, 3, 0, 0, H-1, 0);
      else        send_rows(1, 1'b1, 1'b1, H, 0, 0, H-1, 0);
      nz = 0;
      foreach (capq[i]) if (capq[i].d2 != 12'd0) nz++;
      checks++;
`ifdef SOBEL_MAG_EN
      if (nz != 12) $display("FAIL seltog_nonzero frame=%0d got %0d want 12", f, nz);
`else
      if (nz != ((f == 0) ? 12 : 0)) $display("FAIL seltog_nonzero frame=%0d got %0d want %0d", f, nz, (f == 0) ? 12 : 0);
`endif
      else passes++;
      for (int i = 0; i < expq.size(); i++) begin
        ev_t g;
        g = (i < capq.size()) ? capq[i] : '0;
        checks++;
        if (g !== expq[i]) $display("FAIL seltog[%0d] got %h want %h", i, g, expq[i]);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_midframe;
    expq.delete(); capq.delete();
    send_rows(1, 1'b0, 1'b0, H, 0, 0, 4, 0);
    for (int x = 0; x < 6; x++) drive(x, 5, pix(1, x, 5), 1'b0, 1'b1);
    @(negedge iCLK);
    iRST = 1'b0; iDVAL = 1'b0;
    while (expq.size() > 0 && int'(expq[$].due) > edges) void'(expq.pop_back());
    m_armed = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge iCLK);
      checks++;
      if ({d2, x2, y2, v2, d0, x0, y0, v0} !== '0)
        $display("FAIL rstmid_outputs[%0d] got d=%0d x=%0d y=%0d v=%0d want all 0", k, d2, x2, y2, v2);
      else passes++;
    end
    iRST = 1'b1;
    for (int i = 0; i < expq.size(); i++) begin
      ev_t g;
      g = (i < capq.size()) ? capq[i] : '0;
      checks++;
      if (g !== expq[i]) $display("FAIL rstmid_pre[%0d] got %h want %h", i, g, expq[i]);
      else passes++;
    end
    expq.delete(); capq.delete();
    send_rows(3, 1'b0, 1'b0, H, 0, 5, H-1, 6);
    checks++;
    if (capq.size() != 0) $display("FAIL rstmid_unarmed got %0d events want 0", capq.size());
    else passes++;
    send_rows(1, 1'b0, 1'b0, H, 0, 0, H-1, 0);
    checks++;
    if (capq.size() == 0 || capq[0].x2 !== 11'd1 || capq[0].y2 !== 11'd1)
      $display("FAIL rstmid_first got events=%0d want first at (1,1)", capq.size());
    else passes++;
    for (int i = 0; i < expq.size(); i++) begin
      ev_t g;
      g = (i < capq.size()) ? capq[i] : '0;
      checks++;
      if (g !== expq[i]) $display("FAIL rstmid_post[%0d] got %h want %h", i, g, expq[i]);
      else passes++;
    end
  endtask

  task automatic test_random;
    for (int f = 0; f < 3; f++) begin
      expq.delete(); capq.delete();
      send_rows(3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(1, H-1)), 2, 0, H-1, 0);
      checks++;
      if (capq.size() != expq.size()) $display("FAIL rand_count f=%0d got %0d want %0d", f, capq.size(), expq.size());
      else passes++;
      for (int i = 0; i < expq.size(); i++) begin
        ev_t g;
        g = (i < capq.size()) ? capq[i] : '0;
        checks++;
        if (g !== expq[i]) $display("FAIL rand[%0d] f=%0d got %h want %h", i, f, g, expq[i]);
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_vertical_edge();
    test_horizontal_edge();
    test_dval_gaps();
    test_sel_toggle();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
